// File: rtl/stream_mux_arb_if.sv
// Handshake bundle for stream_mux_arb: N producer streams in, one consumer stream out.
// The mux itself uses the master view; the surrounding environment uses the slave view.
interface stream_mux_arb_if #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SELW  = 3
);
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_ready;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_arb.sv
// Registered N:1 stream multiplexer with fixed-select or round-robin arbitration.
// A single output register decouples input data from output data combinationally.
module stream_mux_arb #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SELW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    stream_mux_arb_if.master bus
);
    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             rr_found;
    int               rr_idx;
    logic [SELW-1:0]  ptr;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_ch_q;
    logic             load_en;
    logic             xfer;

    assign load_en = !out_valid_q || bus.out_ready;

    // One-hot grant; round-robin scans upward from the channel after the last winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        rr_found  = 1'b0;
        rr_idx    = 0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && bus.in_valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                rr_idx = (int'(ptr) + k) % N;
                if (!rr_found && bus.in_valid[rr_idx]) begin
                    rr_found      = 1'b1;
                    grant[rr_idx] = 1'b1;
                    grant_idx     = SELW'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready = reset ? '0 : (grant & {N{load_en}});
    assign xfer         = !reset && load_en && (|grant);

    // Output register and arbitration pointer; reset discards any held beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr         <= SELW'(N - 1);
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
            out_ch_q    <= grant_idx;
            if (mode) begin
                ptr <= grant_idx;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule
